fetch_queue: RTL

Parametrised instruction-fetch stage with a prefetch queue. It generates sequential PCs and issues pipelined requests to a variable-latency, in-order instruction memory. Returned instructions are buffered together with their PCs and handed to decode over a valid/ready handshake. ALU/branch redirects flush the queue and discard responses still in flight.

---
 rtl/fetch_queue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a prefetch queue.
// Issues sequential word-aligned fetches to an in-order, variable-latency
// instruction memory, buffers returned instructions with their PCs, and
// hands them to decode over valid/ready. A redirect flushes the queue and
// discards every response still in flight for the old path.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_inst,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state;

    logic [XLEN-1:0]  fetch_pc;
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] drop_cnt;

    logic [XLEN-1:0]  entry_pc   [DEPTH];
    logic [XLEN-1:0]  entry_inst [DEPTH];
    logic [DEPTH-1:0] entry_filled;

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] rd_idx;

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] outstanding;
    logic [PTR_W:0]   committed;
    logic [PTR_W-1:0] redirect_drop;
    logic [PTR_W-1:0] drop_next;
    logic             issue_fire;
    logic             resp_drop;
    logic             resp_fill;
    logic             deq_fire;

    assign alloc_idx = alloc_ptr[IDX_W-1:0];
    assign fill_idx  = fill_ptr[IDX_W-1:0];
    assign rd_idx    = rd_ptr[IDX_W-1:0];

    // Issue gating, response steering, dequeue and drop-count bookkeeping.
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a value on every path, so no latch can be inferred.
    always_comb begin
        occupancy   = alloc_ptr - rd_ptr;
        outstanding = alloc_ptr - fill_ptr;
        // Entries held plus stale responses still owed by the memory; this
        // caps in-flight requests at DEPTH even while draining.
        committed   = {1'b0, occupancy} + {1'b0, drop_cnt};

        mem_req_valid = rst_n && !redirect_valid && (state != S_BOOT)
                        && (committed < DEPTH_EXT);
        mem_req_addr  = fetch_pc;
        issue_fire    = mem_req_valid && mem_req_ready;

        // Stale responses are consumed first; a response with nothing
        // outstanding is a protocol error and simply ignored.
        resp_drop = mem_resp_valid && (drop_cnt != '0);
        resp_fill = mem_resp_valid && (drop_cnt == '0) && (outstanding != '0);

        inst_valid = entry_filled[rd_idx] && (rd_ptr != fill_ptr);
        inst       = entry_inst[rd_idx];
        inst_pc    = entry_pc[rd_idx];
        // Decode flushes alongside us on a redirect, so its handshake is void.
        deq_fire   = inst_valid && inst_ready && !redirect_valid;

        // Every response still owed by memory becomes stale on a redirect,
        // minus the one that arrives (and is discarded) this very cycle.
        redirect_drop = drop_cnt + outstanding
                        - PTR_W'(resp_drop) - PTR_W'(resp_fill);

        if (redirect_valid) begin
            drop_next = redirect_drop;
        end else if (resp_drop) begin
            drop_next = drop_cnt - PTR_ONE;
        end else begin
            drop_next = drop_cnt;
        end
    end

    // Fetch PC, queue pointers and stale-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (redirect_valid) begin
                fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                rd_ptr    <= '0;
            end else begin
                if (issue_fire) begin
                    alloc_ptr <= alloc_ptr + PTR_ONE;
                    fetch_pc  <= fetch_pc + PC_STEP;
                end
                if (resp_fill) begin
                    fill_ptr <= fill_ptr + PTR_ONE;
                end
                if (deq_fire) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Queue storage: PC captured at issue, instruction captured at response.
    // NOTE: the storage arrays are reset because the head entry drives inst
    // and inst_pc directly, which must read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc[i]   <= '0;
                entry_inst[i] <= '0;
            end
            entry_filled <= '0;
        end else if (redirect_valid) begin
            entry_filled <= '0;
        end else begin
            // Issue, fill and dequeue never target the same slot: the
            // pointer ordering rd <= fill <= alloc with occupancy <= DEPTH
            // rules out every aliasing case that could fire together.
            if (issue_fire) begin
                entry_pc[alloc_idx]     <= fetch_pc;
                entry_filled[alloc_idx] <= 1'b0;
            end
            if (resp_fill) begin
                entry_inst[fill_idx]   <= mem_resp_inst;
                entry_filled[fill_idx] <= 1'b1;
            end
            if (deq_fire) begin
                entry_filled[rd_idx] <= 1'b0;
            end
        end
    end

    // Control FSM: one idle boot cycle, then normal fetch or draining stale
    // responses after a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            case (state)
                S_BOOT:  state <= S_RUN;
                S_RUN:   if (redirect_valid && (redirect_drop != '0)) state <= S_DRAIN;
                S_DRAIN: if (drop_next == '0) state <= S_RUN;
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule
